// File: rtl/bm_dag3_lfsr_misr.sv
// LFSR operand source and MISR response compactor for the 2-bit DAG benchmarks, sequenced by an IDLE/RUN/DRAIN/DONE FSM.
// Define BM_DAG3_GOLDEN_EN to add the golden input and pass output for an on-chip signature compare.
module bm_dag3_lfsr_misr #(
  parameter int unsigned BITS    = 2,
  parameter logic [15:0] NUM_VEC = 16'd16,
  parameter int unsigned LATENCY = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [7:0]      seed,
  input  logic [BITS-1:0] res0_in,
  input  logic            res1_in,
`ifdef BM_DAG3_GOLDEN_EN
  input  logic [7:0]      golden,
  output logic            pass,
`endif
  output logic [BITS-1:0] a_out,
  output logic [BITS-1:0] b_out,
  output logic            c_out,
  output logic            d_out,
  output logic            busy,
  output logic            done,
  output logic [7:0]      signature
);

  localparam int unsigned DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [7:0]         lfsr, misr;
  logic [15:0]        vec_cnt;
  logic [DW-1:0]      drain_cnt;
  logic [LATENCY-1:0] valid_pipe;
  logic               start_ok, last_vec, drain_end, valid_d, running;

  // x^8+x^6+x^5+x^4+1 shift step, shared by the LFSR and the MISR.
  function automatic logic [7:0] step8(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  assign running   = (state == S_RUN);
  assign start_ok  = start && (state == S_IDLE || state == S_DONE);
  assign last_vec  = (vec_cnt == NUM_VEC - 16'd1);
  assign drain_end = (drain_cnt == DW'(LATENCY - 1));
  assign valid_d   = valid_pipe[LATENCY-1];

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt; otherwise a latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start)     state_nxt = S_RUN;
      S_RUN:          if (last_vec)  state_nxt = S_DRAIN;
      S_DRAIN:        if (drain_end) state_nxt = S_DONE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr       <= 8'h01;
      misr       <= 8'h00;
      vec_cnt    <= '0;
      drain_cnt  <= '0;
      valid_pipe <= '0;
    end else begin
      if (start_ok) begin
        lfsr    <= (seed == 8'h00) ? 8'h01 : seed;
        vec_cnt <= '0;
      end else if (running) begin
        lfsr    <= step8(lfsr);
        vec_cnt <= vec_cnt + 16'd1;
      end

      if (running && last_vec)    drain_cnt <= '0;
      else if (state == S_DRAIN)  drain_cnt <= drain_cnt + DW'(1);

      // Truncating the concatenation drops the oldest stage and shifts in the RUN flag.
      valid_pipe <= LATENCY'({valid_pipe, running});

      if (start_ok)     misr <= 8'h00;
      else if (valid_d) misr <= step8(misr) ^ 8'({res1_in, res0_in});
    end
  end

`ifdef BM_DAG3_GOLDEN_EN
  logic [7:0] golden_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      golden_q <= 8'h00;
    else if (start_ok) golden_q <= golden;
  end

  assign pass = (state == S_DONE) && (misr == golden_q);
`endif

  // Operands are only meaningful while vectors are being issued.
  assign a_out     = running ? lfsr[BITS-1:0]      : '0;
  assign b_out     = running ? lfsr[2*BITS-1:BITS] : '0;
  assign c_out     = running & lfsr[2*BITS];
  assign d_out     = running & lfsr[2*BITS+1];
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign signature = misr;

endmodule

// File: tb/tb_bm_dag3_lfsr_misr.sv
// Bench for bm_dag3_lfsr_misr: four instances (NUM_VEC 16/4/1/2) share stimulus and a fake 3-cycle DAG,
// checked every cycle against a sequence-level model of operands, run timing and signature.
module tb_bm_dag3_lfsr_misr;

  localparam int NI  = 4;
  localparam int LAT = 3;
  localparam int RUN_CYC = 16 + LAT + 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       res_force = 1'b0;
  logic [2:0] res_const = 3'b000;
  logic [2:0] dag_pipe [LAT] = '{default: '0};
  logic [1:0] res0;
  logic       res1;

  logic [1:0] a_o [NI];
  logic [1:0] b_o [NI];
  logic       c_o [NI];
  logic       d_o [NI];
  logic       busy_o [NI];
  logic       done_o [NI];
  logic [7:0] sig_o [NI];
`ifdef BM_DAG3_GOLDEN_EN
  logic [7:0] gold = 8'h00;
  logic       pass_o [NI];
`endif

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] lf_m [16];
  logic [2:0] rv_m [16];

  always #5 clock = ~clock;

  function automatic int nv(int g);
    case (g)
      0:       return 16;
      1:       return 4;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  // The benchmark under test: res0 = a+b, res1 = c^d^a[0], delivered LAT cycles later.
  function automatic logic [2:0] dag_f(input logic [1:0] a, input logic [1:0] b, input logic c, input logic d);
    logic [1:0] s;
    s = a + b;
    return {c ^ d ^ a[0], s};
  endfunction

  always @(posedge clock) begin
    dag_pipe[0] <= dag_f(a_o[0], b_o[0], c_o[0], d_o[0]);
    for (int i = 1; i < LAT; i++) dag_pipe[i] <= dag_pipe[i-1];
  end

  assign res0 = res_force ? res_const[1:0] : dag_pipe[LAT-1][1:0];
  assign res1 = res_force ? res_const[2]   : dag_pipe[LAT-1][2];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bm_dag3_lfsr_misr #(.BITS(2), .NUM_VEC(16'(nv(g))), .LATENCY(LAT)) u_dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .seed      (seed),
      .res0_in   (res0),
      .res1_in   (res1),
`ifdef BM_DAG3_GOLDEN_EN
      .golden    (gold),
      .pass      (pass_o[g]),
`endif
      .a_out     (a_o[g]),
      .b_out     (b_o[g]),
      .c_out     (c_o[g]),
      .d_out     (d_o[g]),
      .busy      (busy_o[g]),
      .done      (done_o[g]),
      .signature (sig_o[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Expected operand list and result list for one run.
  task automatic build_model(input logic [7:0] sd, input logic force_en, input logic [2:0] cv);
    logic [7:0] x;
    x = (sd == 8'h00) ? 8'h01 : sd;
    for (int k = 0; k < 16; k++) begin
      lf_m[k] = x;
      rv_m[k] = force_en ? cv : dag_f(x[1:0], x[3:2], x[4], x[5]);
      x = lfsr_next(x);
    end
  endtask

  // Signature after cycle t: results of vectors k with k+LAT+1 <= t folded in order.
  function automatic logic [7:0] exp_sig(input int n, input int t);
    logic [7:0] m;
    m = 8'h00;
    for (int k = 0; k < n; k++)
      if (k + LAT + 1 <= t) m = lfsr_next(m) ^ {5'b0, rv_m[k]};
    return m;
  endfunction

  task automatic check_zero(input string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s busy i%0d", tag, g), 32'(busy_o[g]), 0);
      check($sformatf("%s done i%0d", tag, g), 32'(done_o[g]), 0);
      check($sformatf("%s sig i%0d", tag, g), 32'(sig_o[g]), 0);
      check($sformatf("%s ops i%0d", tag, g), 32'({a_o[g], b_o[g], c_o[g], d_o[g]}), 0);
`ifdef BM_DAG3_GOLDEN_EN
      check($sformatf("%s pass i%0d", tag, g), 32'(pass_o[g]), 0);
`endif
    end
  endtask

  // One run from IDLE or DONE. ign_t: cycle with an extra start pulse (-1 none); abort_t: cycle to reset (-1 none).
  task automatic run(input logic [7:0] sd, input logic force_en, input logic [2:0] cv,
                     input int ign_t, input int abort_t);
    int busy_cnt [NI];
    logic [5:0] ops_e;
    int n;
    build_model(sd, force_en, cv);
    res_force = force_en;
    res_const = cv;
    for (int g = 0; g < NI; g++) busy_cnt[g] = 0;
`ifdef BM_DAG3_GOLDEN_EN
    gold = ($urandom_range(0, 1) == 0) ? exp_sig(16, 99) : 8'($urandom);
`endif
    seed  = sd;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seed  = 8'($urandom);
    for (int t = 0; t < RUN_CYC; t++) begin
      for (int g = 0; g < NI; g++) begin
        n = nv(g);
        ops_e = (t < n) ? {lf_m[t][1:0], lf_m[t][3:2], lf_m[t][4], lf_m[t][5]} : 6'd0;
        check($sformatf("busy i%0d t%0d", g, t), 32'(busy_o[g]), 32'(t < n + LAT));
        check($sformatf("done i%0d t%0d", g, t), 32'(done_o[g]), 32'(t >= n + LAT));
        check($sformatf("ops i%0d t%0d", g, t), 32'({a_o[g], b_o[g], c_o[g], d_o[g]}), 32'(ops_e));
        check($sformatf("sig i%0d t%0d", g, t), 32'(sig_o[g]), 32'(exp_sig(n, t)));
`ifdef BM_DAG3_GOLDEN_EN
        check($sformatf("pass i%0d t%0d", g, t), 32'(pass_o[g]),
              32'((t >= n + LAT) && (exp_sig(n, t) == gold)));
`endif
        if (busy_o[g]) busy_cnt[g]++;
      end
      if (t == abort_t) begin
        reset_n = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clock);
        reset_n = 1'b1;
        return;
      end
      start = (t == ign_t);
      @(negedge clock);
    end
    start = 1'b0;
    for (int g = 0; g < NI; g++)
      check($sformatf("busy_len i%0d", g), 32'(busy_cnt[g]), 32'(nv(g) + LAT));
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_zero("por");
    reset_n = 1'b1;
    @(negedge clock);
    check_zero("idle");

    run(8'h01, 1'b0, 3'b000, -1, -1);
    check("seed01 n4 busy", 32'(busy_o[1]), 0);
    run(8'h00, 1'b0, 3'b000, 2, -1);
    run(8'($urandom), 1'b1, 3'b000, -1, -1);
    check("zero res sig", 32'(sig_o[0]), 32'h00);
    run(8'($urandom), 1'b1, 3'b001, $urandom_range(1, 3), -1);
    check("misr n1 sig", 32'(sig_o[2]), 32'h01);
    check("misr n2 sig", 32'(sig_o[3]), 32'h03);
    run(8'($urandom), 1'b0, 3'b000, -1, 2);
    run(8'($urandom), 1'b0, 3'b000, -1, -1);
    for (int r = 0; r < 6; r++)
      run(8'($urandom), 1'b0, 3'b000, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 3)), -1);
    run(8'($urandom), 1'b1, 3'($urandom), -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
